// File: rtl/rx_8b10b_sync_ctrl.sv
// rx_8b10b_sync_ctrl: comma-based word sync FSM for an 8b/10b receiver.
// Only valid words accepted while in SYNC reach the decoder through a one-deep output register.
module rx_8b10b_sync_ctrl #(
    parameter int comma_count_p = 3,
    parameter int err_thresh_p  = 4,
    parameter int good_run_p    = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [9:0]  data_i,
    input  logic        v_i,
    output logic        ready_o,
    output logic [9:0]  data_o,
    output logic        v_o,
    input  logic        yumi_i,
    output logic        dec_enable_o,
    output logic        comma_o,
    output logic        sync_o,
    output logic [1:0]  state_o,
    output logic [15:0] err_count_o
);
    localparam logic [1:0] los_s  = 2'b00;
    localparam logic [1:0] acq_s  = 2'b01;
    localparam logic [1:0] sync_s = 2'b10;
    localparam logic [9:0] comma_n = 10'b0011111010;
    localparam logic [9:0] comma_p = 10'b1100000101;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cc_q, cc_d, bad_q, bad_d, good_q, good_d;
    logic [9:0]  data_q, data_d;
    logic        v_q, v_d, comma_q, comma_d;
    logic [15:0] err_q, err_d;
    logic [2:0]  hi, lo;
    logic [3:0]  tot;
    logic        acc, ok, is_comma, load;

    function automatic logic [2:0] pop5(input logic [4:0] x);
        return 3'(x[0]) + 3'(x[1]) + 3'(x[2]) + 3'(x[3]) + 3'(x[4]);
    endfunction

    assign ready_o      = ~v_q | yumi_i;
    assign data_o       = data_q;
    assign v_o          = v_q;
    assign dec_enable_o = v_q;
    assign comma_o      = comma_q;
    assign sync_o       = state_q == sync_s;
    assign state_o      = state_q;
    assign err_count_o  = err_q;

    always_comb begin
        hi       = pop5(data_i[9:5]);
        lo       = pop5(data_i[4:0]);
        tot      = {1'b0, hi} + {1'b0, lo};
        ok       = hi != 3'd0 && hi <= 3'd4 && lo != 3'd0 && lo <= 3'd4 && tot >= 4'd4 && tot <= 4'd6;
        is_comma = data_i == comma_n || data_i == comma_p;
        acc      = v_i & ready_o;
        load     = acc & ok & (state_q == sync_s);
        v_d      = load | (v_q & ~yumi_i);
        data_d   = load ? data_i : data_q;
        comma_d  = load ? is_comma : comma_q;
        err_d    = (acc & ~ok & ~&err_q) ? err_q + 16'd1 : err_q;
        state_d  = state_q;
        cc_d     = cc_q;
        bad_d    = bad_q;
        good_d   = good_q;
        if (acc) begin
            case (state_q)
                sync_s: begin
                    if (!ok) begin
                        good_d = 4'd0;
                        if (bad_q + 4'd1 == 4'(err_thresh_p)) begin
                            state_d = los_s;
                            bad_d   = 4'd0;
                            cc_d    = 4'd0;
                        end else begin
                            bad_d = bad_q + 4'd1;
                        end
                    end else if (good_q + 4'd1 == 4'(good_run_p)) begin
                        good_d = 4'd0;
                        bad_d  = (bad_q != 4'd0) ? bad_q - 4'd1 : bad_q;
                    end else begin
                        good_d = good_q + 4'd1;
                    end
                end
                acq_s: begin
                    if (is_comma) begin
                        cc_d    = cc_q + 4'd1;
                        state_d = (cc_q + 4'd1 == 4'(comma_count_p)) ? sync_s : acq_s;
                    end else if (!ok) begin
                        state_d = los_s;
                        cc_d    = 4'd0;
                    end
                end
                default: begin
                    cc_d    = is_comma ? 4'd1 : 4'd0;
                    state_d = !is_comma ? los_s : (comma_count_p == 1) ? sync_s : acq_s;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= los_s;
            cc_q    <= 4'd0;
            bad_q   <= 4'd0;
            good_q  <= 4'd0;
            data_q  <= 10'd0;
            v_q     <= 1'b0;
            comma_q <= 1'b0;
            err_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            cc_q    <= cc_d;
            bad_q   <= bad_d;
            good_q  <= good_d;
            data_q  <= data_d;
            v_q     <= v_d;
            comma_q <= comma_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_rx_8b10b_sync_ctrl.sv
// tb_rx_8b10b_sync_ctrl: directed and random checks of the sync controller against a rule-level model.
module tb_rx_8b10b_sync_ctrl;
    localparam int CC = 3, ET = 4, GR = 4;
    localparam logic [9:0] K  = 10'b0011111010;
    localparam logic [9:0] KP = 10'b1100000101;
    localparam logic [9:0] D  = 10'b1010101010;
    localparam logic [9:0] G2 = 10'b0110110001;
    localparam logic [9:0] BAD1 = 10'b1111111111;
    localparam logic [9:0] BAD0 = 10'b0000000000;

    logic clk = 0, reset_i = 0, v_i = 0, yumi_i = 0;
    logic [9:0] data_i = '0;
    logic ready_o, v_o, dec_enable_o, comma_o, sync_o;
    logic [9:0] data_o;
    logic [1:0] state_o;
    logic [15:0] err_count_o;
    int checks = 0, failures = 0;

    // model: phase 0 = hunting, 1 = acquiring, 2 = locked
    int ms, mcc, mbad, mgood, merr;
    bit mv, mc;
    logic [9:0] md;

    rx_8b10b_sync_ctrl #(.comma_count_p(CC), .err_thresh_p(ET), .good_run_p(GR)) dut (
        .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .v_i(v_i), .ready_o(ready_o),
        .data_o(data_o), .v_o(v_o), .yumi_i(yumi_i), .dec_enable_o(dec_enable_o),
        .comma_o(comma_o), .sync_o(sync_o), .state_o(state_o), .err_count_o(err_count_o));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit word_ok(input logic [9:0] d);
        int h, l;
        h = $countones(d[9:5]);
        l = $countones(d[4:0]);
        return h >= 1 && h <= 4 && l >= 1 && l <= 4 && h + l >= 4 && h + l <= 6;
    endfunction

    task automatic check_all();
        chk("state", {14'd0, state_o}, ms[15:0]);
        chk("sync", {15'd0, sync_o}, {15'd0, ms == 2});
        chk("v_o", {15'd0, v_o}, {15'd0, mv});
        chk("dec_en", {15'd0, dec_enable_o}, {15'd0, mv});
        chk("err", err_count_o, merr[15:0]);
        if (mv) begin
            chk("data", {6'd0, data_o}, {6'd0, md});
            chk("comma", {15'd0, comma_o}, {15'd0, mc});
        end
    endtask

    task automatic do_reset();
        reset_i = 1; v_i = 1; yumi_i = 1; data_i = K;
        @(posedge clk);
        ms = 0; mcc = 0; mbad = 0; mgood = 0; merr = 0; mv = 0; mc = 0; md = '0;
        #1;
        reset_i = 0; v_i = 0; yumi_i = 0;
        check_all();
        chk("rst_data", {6'd0, data_o}, 16'd0);
        chk("rst_comma", {15'd0, comma_o}, 16'd0);
        #1 chk("rst_ready", {15'd0, ready_o}, 16'd1);
    endtask

    task automatic cyc(input logic v, input logic [9:0] d, input logic y);
        bit acc, ok, cm, ld;
        v_i = v; data_i = d; yumi_i = y;
        #1 chk("ready", {15'd0, ready_o}, {15'd0, !mv || y});
        @(posedge clk);
        acc = v && (!mv || y);
        ok = word_ok(d);
        cm = d == K || d == KP;
        ld = acc && ms == 2 && ok;
        if (ld) begin md = d; mc = cm; end
        mv = ld || (mv && !y);
        if (acc && !ok && merr < 65535) merr++;
        if (acc) begin
            if (ms == 0) begin
                if (cm) begin mcc = 1; ms = (CC == 1) ? 2 : 1; end
            end else if (ms == 1) begin
                if (cm) begin mcc++; if (mcc >= CC) ms = 2; end
                else if (!ok) begin ms = 0; mcc = 0; end
            end else if (!ok) begin
                mbad++; mgood = 0;
                if (mbad >= ET) begin ms = 0; mbad = 0; mcc = 0; end
            end else begin
                mgood++;
                if (mgood >= GR) begin mgood = 0; if (mbad > 0) mbad--; end
            end
        end
        #1 check_all();
    endtask

    task automatic send(input logic [9:0] d);
        cyc(1'b1, d, mv);
    endtask

    initial begin
        logic [9:0] w;
        @(posedge clk); #1;
        do_reset();
        send(K); chk("acq1", {14'd0, state_o}, 16'd1);
        send(K); chk("acq2", {14'd0, state_o}, 16'd1);
        send(K); chk("sync3", {14'd0, state_o}, 16'd2);
        send(D);
        chk("fwd_data", {6'd0, data_o}, {6'd0, D});
        chk("fwd_v", {15'd0, v_o}, 16'd1);
        cyc(1'b0, '0, 1'b1);
        chk("fwd_v_clr", {15'd0, v_o}, 16'd0);
        for (int i = 0; i < 4; i++) begin
            send(BAD1);
            if (i < 3) for (int j = 0; j < 3; j++) send(G2);
        end
        chk("los_after4", {14'd0, state_o}, 16'd0);
        chk("err4", err_count_o, 16'd4);
        do_reset();
        repeat (3) send(K);
        for (int i = 0; i < 10; i++) begin
            send(BAD1);
            repeat (4) send(G2);
            chk("bad_le1", mbad[15:0] <= 16'd1 ? 16'd1 : 16'd0, {15'd0, state_o == 2'b10});
        end
        chk("forgive_state", {14'd0, state_o}, 16'd2);
        chk("err10", err_count_o, 16'd10);
        do_reset();
        send(K); send(K); send(BAD0);
        chk("acq_drop", {14'd0, state_o}, 16'd0);
        send(K); send(KP);
        chk("reacq2", {14'd0, state_o}, 16'd1);
        send(K);
        chk("reacq3", {14'd0, state_o}, 16'd2);
        send(KP);
        chk("comma_fwd", {15'd0, comma_o}, 16'd1);
        cyc(1'b1, G2, 1'b1);
        repeat (5) cyc(1'b1, D, 1'b0);
        chk("stall_data", {6'd0, data_o}, {6'd0, G2});
        cyc(1'b1, D, 1'b1);
        chk("swap_data", {6'd0, data_o}, {6'd0, D});
        chk("swap_v", {15'd0, v_o}, 16'd1);
        do_reset();
        chk("rst_state", {14'd0, state_o}, 16'd0);
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 5))
                0: w = ($urandom_range(0, 1) != 0) ? K : KP;
                1, 2: w = G2 ^ {5'd0, 5'($urandom_range(0, 1) != 0 ? 5'b00000 : 5'b00011)};
                default: w = 10'($urandom);
            endcase
            if ($urandom_range(0, 99) == 0) do_reset();
            else cyc(1'($urandom_range(0, 3) != 0), w, mv && ($urandom_range(0, 2) != 0));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rx_8b10b_sync_ctrl.md
RX_8B10B_SYNC_CTRL -- requirements
Module: rx_8b10b_sync_ctrl

Interface
REQ-001 Parameter comma_count_p, default 3: consecutive-in-ACQ commas needed to enter SYNC (range 1..15).
REQ-002 Parameter err_thresh_p, default 4: code violations in SYNC that force loss of sync (range 1..15).
REQ-003 Parameter good_run_p, default 4: consecutive valid words in SYNC that forgive one violation (range 1..15).
REQ-004 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-005 reset_i  in  1  synchronous, active-high reset.
REQ-006 data_i  in  10  10b symbol; bits [9:5] upper sub-block, [4:0] lower sub-block.
REQ-007 v_i  in  1  data_i valid.
REQ-008 ready_o  out  1  block can accept data_i this cycle.
REQ-009 data_o  out  10  registered symbol presented to the 8b/10b decoder.
REQ-010 v_o  out  1  data_o valid.
REQ-011 yumi_i  in  1  consumer takes data_o this cycle; legal only while v_o=1.
REQ-012 dec_enable_o  out  1  decoder enable; equals v_o.
REQ-013 comma_o  out  1  data_o is a comma symbol; qualified by v_o.
REQ-014 sync_o  out  1  high while FSM is in SYNC.
REQ-015 state_o  out  2  FSM state: 00 LOS, 01 ACQ, 10 SYNC.
REQ-016 err_count_o  out  16  saturating count of all accepted code violations.

Function
REQ-017 Accept = v_i & ready_o; ready_o = ~v_o | yumi_i (combinational, single output register).
REQ-018 Valid word: popcount(data_i[9:5]) in 1..4, popcount(data_i[4:0]) in 1..4, total popcount in 4..6; any other word is a code violation.
REQ-019 Comma: data_i == 10'b0011111010 or 10'b1100000101; a comma is always a valid word.
REQ-020 LOS: accepted comma -> ACQ with comma counter = 1; all other words -> stay in LOS.
REQ-021 ACQ: accepted comma -> counter +1, then -> SYNC when counter reaches comma_count_p; accepted violation -> LOS, counter = 0; valid non-comma -> stay, counter held.
REQ-022 comma_count_p = 1: first accepted comma in LOS -> SYNC directly.
REQ-023 SYNC: accepted violation -> bad count +1, good run = 0; -> LOS (bad count, good run, comma counter cleared) when bad count reaches err_thresh_p.
REQ-024 SYNC: accepted valid word -> good run +1; when good run reaches good_run_p: good run = 0 and bad count -1 if bad count > 0.
REQ-025 Forwarding: word loaded into output register iff accepted, state is SYNC in the accepting cycle, and word is valid; comma_o loaded with comma flag.
REQ-026 Words accepted in LOS/ACQ and violations in any state are consumed and dropped, never forwarded.
REQ-027 The comma completing acquisition is not forwarded (state changes the cycle after acceptance).
REQ-028 Latency: forwarded word appears on data_o/v_o the cycle after acceptance.
REQ-029 v_o clears on yumi_i unless a new word loads the same cycle; simultaneous yumi_i and load keeps v_o = 1 with new data.
REQ-030 Word already held in output register when sync is lost stays valid until yumi_i.
REQ-031 err_count_o increments on every accepted violation in any state; holds at 16'hFFFF.
REQ-032 sync_o and state_o are registered, updated the cycle after the causing acceptance.

Reset
REQ-033 reset_i high at a clock edge: state = LOS, all counters = 0, v_o = 0, comma_o = 0, data_o = 0, err_count_o = 0; sync_o = 0, ready_o = 1 the following cycle.
REQ-034 Reset mid-operation discards any held output word with no yumi_i required; reset overrides simultaneous v_i/yumi_i.

Verification
REQ-035 After reset, 3 accepted commas 10'b0011111010, then data 10'b1010101010 with yumi_i=1 -> state_o 00->01->01->10, data 10'b1010101010 on data_o one cycle after acceptance, v_o = 1 for one cycle.
REQ-036 In SYNC, 4 violations 10'b1111111111 separated by 3 valid words each -> state_o = 00 after the 4th violation, err_count_o = 4.
REQ-037 In SYNC, violation, 4 valid words, violation, 4 valid words, repeated 10 times -> state stays SYNC, bad count never exceeds 1, err_count_o = 10.
REQ-038 ACQ after 2 commas, then violation 10'b0000000000 -> LOS; 3 further commas needed for SYNC.
REQ-039 In SYNC, v_o = 1 with yumi_i = 0 for 5 cycles -> ready_o = 0, data_o stable; yumi_i = 1 with v_i = 1 -> new word loaded, v_o stays 1.
REQ-040 Reset asserted while v_o = 1 in SYNC -> v_o = 0, state_o = 00, err_count_o = 0 the next cycle.
